// File: rtl/riscv_pkg.sv
// Shared opcode constants, FSM state encoding, opcode class type and mux select
// encodings for the RV32I multi-cycle control sequencer.
package riscv_pkg;

    localparam logic [6:0] OP_ALU_REG = 7'b0110011;
    localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

    localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SEL_IMM   = 2'd1;
    localparam logic [1:0] PC_SEL_JALR  = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    typedef struct packed {
        logic alu_reg;
        logic alu_imm;
        logic branch;
        logic jalr;
        logic jal;
        logic auipc;
        logic lui;
        logic load;
        logic store;
        logic system;
    } opclass_t;

    function automatic logic uses_imm(input opclass_t c);
        return c.alu_imm | c.load | c.store | c.jalr;
    endfunction

    function automatic logic writes_rd(input opclass_t c);
        return c.alu_reg | c.alu_imm | c.jalr | c.jal | c.auipc | c.lui | c.load;
    endfunction

endpackage

// File: rtl/riscv_opclass.sv
// Combinational opcode classifier: instr[6:0] to a one-hot class vector; an
// all-zero vector raises the illegal flag.
module riscv_opclass
    import riscv_pkg::*;
(
    input  logic [6:0] i_opcode,
    output opclass_t   o_cls,
    output logic       o_illegal
);

    // One-hot opcode decode
    always_comb begin
        o_cls = '0;
        case (i_opcode)
            OP_ALU_REG: o_cls.alu_reg = 1'b1;
            OP_ALU_IMM: o_cls.alu_imm = 1'b1;
            OP_BRANCH:  o_cls.branch  = 1'b1;
            OP_JALR:    o_cls.jalr    = 1'b1;
            OP_JAL:     o_cls.jal     = 1'b1;
            OP_AUIPC:   o_cls.auipc   = 1'b1;
            OP_LUI:     o_cls.lui     = 1'b1;
            OP_LOAD:    o_cls.load    = 1'b1;
            OP_STORE:   o_cls.store   = 1'b1;
            OP_SYSTEM:  o_cls.system  = 1'b1;
            default:    o_cls = '0;
        endcase
        o_illegal = (o_cls == '0);
    end

endmodule

// File: rtl/riscv_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer (fetch/decode/execute/mem/writeback).
// Optional macro RISCV_TRAP_ILLEGAL_EN halts on unknown opcodes and adds illegal_o.
module riscv_ctrl_fsm
    import riscv_pkg::*;
#(
    parameter int RESET_HOLD = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        alu_src_imm,
    output logic        halted
`ifdef RISCV_TRAP_ILLEGAL_EN
    ,
    output logic        illegal_o
`endif
);

    localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    state_t        r_state, w_ns;
    opclass_t      w_cls, r_cls, w_cls_use;
    logic          w_illegal, w_rd_nz, w_unused;
    logic [HW-1:0] r_hold_cnt;

    logic       r_mem_req, r_mem_we, r_mem_addr_sel, r_ir_arm, r_pc_we, r_br;
    logic       r_rf_we, r_alu_src_imm, r_halted;
    logic [1:0] r_pc_sel, r_wb_sel;
    logic       w_mem_req, w_mem_we, w_mem_addr_sel, w_ir_arm, w_pc_we, w_br;
    logic       w_rf_we, w_alu_src_imm, w_halted;
    logic [1:0] w_pc_sel, w_wb_sel;
`ifdef RISCV_TRAP_ILLEGAL_EN
    logic       r_illegal;
`endif

    riscv_opclass u_opclass (
        .i_opcode  (instr[6:0]),
        .o_cls     (w_cls),
        .o_illegal (w_illegal)
    );

    assign w_rd_nz   = |instr[11:7];
    // The class is only latched at the end of DECODE, so use the live decode there.
    assign w_cls_use = (r_state == S_DECODE) ? w_cls : r_cls;
    assign w_unused  = &{1'b0, instr[31:12], w_illegal};

    // Next-state selection
    always_comb begin
        w_ns = r_state;
        case (r_state)
            S_RESET:   w_ns = (r_hold_cnt == HW'(RESET_HOLD - 1)) ? S_FETCH : S_RESET;
            S_FETCH:   w_ns = mem_ready ? S_DECODE : S_FETCH;
`ifdef RISCV_TRAP_ILLEGAL_EN
            S_DECODE:  w_ns = w_illegal ? S_HALT : S_EXECUTE;
`else
            S_DECODE:  w_ns = S_EXECUTE;
`endif
            S_EXECUTE: begin
                if (r_cls.load || r_cls.store) begin
                    w_ns = S_MEM;
                end else if (r_cls.branch) begin
                    w_ns = S_FETCH;
                end else if (r_cls.system) begin
                    w_ns = S_HALT;
                end else begin
                    w_ns = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    w_ns = r_cls.load ? S_WB : S_FETCH;
                end else begin
                    w_ns = S_MEM;
                end
            end
            S_WB:      w_ns = S_FETCH;
            S_HALT:    w_ns = S_HALT;
            default:   w_ns = S_RESET;
        endcase
    end

    // Output values for the state being entered, registered with the state
    always_comb begin
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr_sel = 1'b0;
        w_ir_arm       = 1'b0;
        w_pc_we        = 1'b0;
        w_br           = 1'b0;
        w_pc_sel       = PC_SEL_PLUS4;
        w_rf_we        = 1'b0;
        w_wb_sel       = WB_SEL_ALU;
        w_alu_src_imm  = 1'b0;
        w_halted       = 1'b0;
        case (w_ns)
            S_FETCH: begin
                w_mem_req = 1'b1;
                w_ir_arm  = 1'b1;
            end
            S_EXECUTE: begin
                w_alu_src_imm = uses_imm(w_cls_use);
                w_pc_we       = w_cls_use.branch;
                w_br          = w_cls_use.branch;
            end
            S_MEM: begin
                w_mem_req      = 1'b1;
                w_mem_addr_sel = 1'b1;
                w_mem_we       = w_cls_use.store;
                w_pc_we        = w_cls_use.store;
                w_alu_src_imm  = uses_imm(w_cls_use);
            end
            S_WB: begin
                w_rf_we       = writes_rd(w_cls_use) & w_rd_nz;
                w_pc_we       = 1'b1;
                w_alu_src_imm = uses_imm(w_cls_use);
                if (w_cls_use.load) begin
                    w_wb_sel = WB_SEL_MEM;
                end else if (w_cls_use.jal || w_cls_use.jalr) begin
                    w_wb_sel = WB_SEL_PC4;
                end else begin
                    w_wb_sel = WB_SEL_ALU;
                end
                if (w_cls_use.jal) begin
                    w_pc_sel = PC_SEL_IMM;
                end else if (w_cls_use.jalr) begin
                    w_pc_sel = PC_SEL_JALR;
                end else begin
                    w_pc_sel = PC_SEL_PLUS4;
                end
            end
            S_HALT:  w_halted = 1'b1;
            default: w_halted = 1'b0;
        endcase
    end

    // State, class latch, reset hold counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_RESET;
            r_cls          <= '0;
            r_hold_cnt     <= '0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr_sel <= 1'b0;
            r_ir_arm       <= 1'b0;
            r_pc_we        <= 1'b0;
            r_br           <= 1'b0;
            r_pc_sel       <= PC_SEL_PLUS4;
            r_rf_we        <= 1'b0;
            r_wb_sel       <= WB_SEL_ALU;
            r_alu_src_imm  <= 1'b0;
            r_halted       <= 1'b0;
`ifdef RISCV_TRAP_ILLEGAL_EN
            r_illegal      <= 1'b0;
`endif
        end else begin
            r_state        <= w_ns;
            r_mem_req      <= w_mem_req;
            r_mem_we       <= w_mem_we;
            r_mem_addr_sel <= w_mem_addr_sel;
            r_ir_arm       <= w_ir_arm;
            r_pc_we        <= w_pc_we;
            r_br           <= w_br;
            r_pc_sel       <= w_pc_sel;
            r_rf_we        <= w_rf_we;
            r_wb_sel       <= w_wb_sel;
            r_alu_src_imm  <= w_alu_src_imm;
            r_halted       <= w_halted;
            if (r_state == S_RESET) begin
                r_hold_cnt <= r_hold_cnt + HW'(1);
            end
            if (r_state == S_DECODE) begin
                r_cls <= w_cls;
            end
`ifdef RISCV_TRAP_ILLEGAL_EN
            if (r_state == S_DECODE && w_illegal) begin
                r_illegal <= 1'b1;
            end
`endif
        end
    end

    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr_sel = r_mem_addr_sel;
    // Write enables in request states only fire once the memory completes.
    assign ir_we        = r_ir_arm & mem_ready;
    assign pc_we        = r_pc_we & (mem_ready | ~r_mem_req);
    assign pc_sel       = r_br ? {1'b0, branch_taken} : r_pc_sel;
    assign rf_we        = r_rf_we;
    assign wb_sel       = r_wb_sel;
    assign alu_src_imm  = (r_state == S_DECODE) ? uses_imm(w_cls) : r_alu_src_imm;
    assign halted       = r_halted;
`ifdef RISCV_TRAP_ILLEGAL_EN
    assign illegal_o    = r_illegal;
`endif

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// Self-checking bench for riscv_ctrl_fsm: directed test-plan cases plus random
// instructions and wait states, checked per cycle against a phase-level model.
module tb_riscv_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, alu_src_imm, halted;
    logic [1:0]  pc_sel, wb_sel;
`ifdef RISCV_TRAP_ILLEGAL_EN
    logic        illegal_o;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] cur_ir = 32'h0;

    localparam int K_ALUR = 0, K_ALUI = 1, K_BR = 2, K_JALR = 3, K_JAL = 4;
    localparam int K_AUIPC = 5, K_LUI = 6, K_LOAD = 7, K_STORE = 8, K_SYS = 9, K_ILL = 10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       src_imm;
        logic       halted;
    } outv_t;

    riscv_ctrl_fsm #(.RESET_HOLD(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .alu_src_imm  (alu_src_imm),
        .halted       (halted)
`ifdef RISCV_TRAP_ILLEGAL_EN
        ,
        .illegal_o    (illegal_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int kind_of(input logic [6:0] op);
        case (op)
            7'b0110011: return K_ALUR;
            7'b0010011: return K_ALUI;
            7'b1100011: return K_BR;
            7'b1100111: return K_JALR;
            7'b1101111: return K_JAL;
            7'b0010111: return K_AUIPC;
            7'b0110111: return K_LUI;
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b1110011: return K_SYS;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic outv_t sample();
        outv_t o;
        o.mem_req  = mem_req;
        o.mem_we   = mem_we;
        o.addr_sel = mem_addr_sel;
        o.ir_we    = ir_we;
        o.pc_we    = pc_we;
        o.pc_sel   = pc_sel;
        o.rf_we    = rf_we;
        o.wb_sel   = wb_sel;
        o.src_imm  = alu_src_imm;
        o.halted   = halted;
        return o;
    endfunction

    // One clock: drive inputs at negedge, compare cared fields 1ns later.
    task automatic cycle(input string tag, input logic [31:0] ins, input logic rdy, input logic bt,
                         input outv_t exp, input logic wb_care, input logic src_care);
        outv_t care;
        logic [11:0] ov, ev, cv;
        care          = '1;
        care.pc_sel   = exp.pc_we ? 2'b11 : 2'b00;
        care.mem_we   = exp.mem_req;
        care.addr_sel = exp.mem_req;
        care.wb_sel   = wb_care ? 2'b11 : 2'b00;
        care.src_imm  = src_care;
        @(negedge clk);
        instr        = ins;
        mem_ready    = rdy;
        branch_taken = bt;
        #1;
        ov = sample();
        ev = exp;
        cv = care;
        check_val(tag, {20'd0, ov & cv}, {20'd0, ev & cv});
        @(posedge clk);
    endtask

    task automatic do_reset(input logic pre_mem);
        logic [11:0] ov;
        outv_t e;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        if (pre_mem) check_val("mem_pre_rst", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        ov = sample();
        check_val("rst_async_zero", {20'd0, ov}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        e = '0;
        cycle("rst_hold", cur_ir, rb(), rb(), e, 1'b1, 1'b1);
`ifdef RISCV_TRAP_ILLEGAL_EN
        check_val("illegal_clr", {31'd0, illegal_o}, 32'd0);
`endif
    endtask

    task automatic halt_seq(input logic [31:0] ins, input int n);
        outv_t e;
        for (int i = 0; i < n; i++) begin
            e = '0;
            e.halted = 1'b1;
            cycle("halt", ins, rb(), rb(), e, 1'b0, 1'b0);
        end
`ifdef RISCV_TRAP_ILLEGAL_EN
        check_val("illegal_o", {31'd0, illegal_o}, {31'd0, kind_of(ins[6:0]) == K_ILL});
`endif
        do_reset(1'b0);
    endtask

    // Phase-level model of one instruction: fetch(+waits), decode, execute, mem(+waits), wb.
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input int bt_mode, input logic abort_mem, input int halt_n);
        int    k;
        logic  bt, rd_nz;
        outv_t e;
        k     = kind_of(ins[6:0]);
        rd_nz = |ins[11:7];
        for (int i = 0; i < fw; i++) begin
            e = '0;
            e.mem_req = 1'b1;
            cycle("fetch_wait", cur_ir, 1'b0, rb(), e, 1'b0, 1'b0);
        end
        e = '0;
        e.mem_req = 1'b1;
        e.ir_we   = 1'b1;
        cycle("fetch", cur_ir, 1'b1, rb(), e, 1'b0, 1'b0);
        cur_ir = ins;
        e = '0;
        e.src_imm = (k == K_ALUI) || (k == K_LOAD) || (k == K_STORE) || (k == K_JALR);
        cycle("decode", ins, rb(), rb(), e, 1'b0, 1'b1);
`ifdef RISCV_TRAP_ILLEGAL_EN
        if (k == K_ILL) begin
            halt_seq(ins, halt_n);
            return;
        end
`endif
        bt = (bt_mode == 2) ? rb() : (bt_mode == 1);
        e = '0;
        if (k == K_BR) begin
            e.pc_we  = 1'b1;
            e.pc_sel = {1'b0, bt};
        end
        cycle("execute", ins, rb(), bt, e, 1'b0, 1'b0);
        if (k == K_BR) return;
        if (k == K_SYS) begin
            halt_seq(ins, halt_n);
            return;
        end
        if (k == K_LOAD || k == K_STORE) begin
            for (int i = 0; i < mw; i++) begin
                e = '0;
                e.mem_req  = 1'b1;
                e.addr_sel = 1'b1;
                e.mem_we   = (k == K_STORE);
                cycle("mem_wait", ins, 1'b0, rb(), e, 1'b0, 1'b0);
            end
            if (abort_mem) begin
                do_reset(1'b1);
                return;
            end
            e = '0;
            e.mem_req  = 1'b1;
            e.addr_sel = 1'b1;
            e.mem_we   = (k == K_STORE);
            e.pc_we    = (k == K_STORE);
            cycle("mem", ins, 1'b1, rb(), e, 1'b0, 1'b0);
            if (k == K_STORE) return;
        end
        e = '0;
        e.rf_we  = rd_nz && (k != K_ILL);
        e.wb_sel = (k == K_LOAD) ? 2'd1 : ((k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0);
        e.pc_we  = 1'b1;
        e.pc_sel = (k == K_JAL) ? 2'd1 : ((k == K_JALR) ? 2'd2 : 2'd0);
        cycle("wb", ins, rb(), rb(), e, 1'b1, 1'b0);
    endtask

    logic [6:0] ops [11] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b1100111, 7'b1101111,
                             7'b0010111, 7'b0110111, 7'b0000011, 7'b0100011, 7'b1110011,
                             7'b1111111};

    initial begin
        logic [11:0] ov;
        logic [31:0] r;
        outv_t e;
        repeat (2) @(posedge clk);
        #1;
        ov = sample();
        check_val("por_zero", {20'd0, ov}, 32'd0);
        rst_n = 1'b1;
        e = '0;
        cycle("rst_hold", cur_ir, 1'b1, 1'b0, e, 1'b1, 1'b1);

        run_instr(32'h00500093, 0, 0, 2, 1'b0, 0);
        run_instr(32'h0000A103, 0, 2, 2, 1'b0, 0);
        run_instr(32'h00208463, 0, 0, 1, 1'b0, 0);
        run_instr(32'h00208463, 1, 0, 0, 1'b0, 0);
        run_instr(32'h000280E7, 0, 0, 2, 1'b0, 0);
        run_instr(32'h0000006F, 2, 0, 2, 1'b0, 0);
        run_instr(32'h0020A023, 0, 1, 2, 1'b0, 0);
        run_instr(32'h0000A103, 0, 2, 2, 1'b1, 0);
        run_instr(32'h00500093, 0, 0, 2, 1'b0, 0);
        run_instr(32'h00000073, 0, 0, 2, 1'b0, 20);
        run_instr(32'hFFFFFFFF, 0, 0, 2, 1'b0, 5);

        for (int n = 0; n < 80; n++) begin
            r = $urandom();
            r[6:0] = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 3) == 0) r[11:7] = 5'd0;
            run_instr(r, $urandom_range(0, 2), $urandom_range(0, 2), 2, 1'b0, 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
